// File: rtl/mem_bus_arbiter.sv
// Shares one SRAM-like bus between instruction fetch and MEM-stage data, one transaction at a time.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise the data port has fixed priority.
module mem_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic [DATA_W-1:0] inst_rdata,
  output logic              inst_ready,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [2:0]        data_size,
  input  logic [3:0]        data_wstrb,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic [DATA_W-1:0] data_rdata,
  output logic              data_ready,
  output logic              bus_req,
  output logic              bus_wr,
  output logic [2:0]        bus_size,
  output logic [3:0]        bus_wstrb,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_addr_ok,
  input  logic              bus_data_ok,
  input  logic [DATA_W-1:0] bus_rdata
);
  typedef enum logic [1:0] {IDLE, GRANT, WAIT_DATA, DONE} state_e;
  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_wr_q, bus_wr_d;
  logic [2:0]        bus_size_q, bus_size_d;
  logic [3:0]        bus_wstrb_q, bus_wstrb_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic [DATA_W-1:0] inst_rdata_q, inst_rdata_d;
  logic [DATA_W-1:0] data_rdata_q, data_rdata_d;
  logic              inst_ready_q, inst_ready_d;
  logic              data_ready_q, data_ready_d;
  logic              pick_data;
  logic              complete;

`ifdef MEM_ARB_RR_EN
  logic last_owner_q, last_owner_d;
  // On a conflict the port that did not win last time gets the bus.
  assign pick_data = data_req & (~inst_req | (last_owner_q == OWN_INST));
`else
  assign pick_data = data_req;
`endif

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    bus_req_d    = bus_req_q;
    bus_wr_d     = bus_wr_q;
    bus_size_d   = bus_size_q;
    bus_wstrb_d  = bus_wstrb_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    inst_ready_d = 1'b0;
    data_ready_d = 1'b0;
    complete     = 1'b0;
`ifdef MEM_ARB_RR_EN
    last_owner_d = last_owner_q;
`endif
    case (state_q)
      IDLE: if (inst_req | data_req) begin
        state_d   = GRANT;
        bus_req_d = 1'b1;
        if (pick_data) begin
          owner_d     = OWN_DATA;
          bus_wr_d    = data_wr;
          bus_size_d  = data_size;
          bus_wstrb_d = data_wstrb;
          bus_addr_d  = data_addr;
          bus_wdata_d = data_wdata;
        end else begin
          owner_d     = OWN_INST;
          bus_wr_d    = 1'b0;
          bus_size_d  = 3'd2;
          bus_wstrb_d = 4'd0;
          bus_addr_d  = inst_addr;
          bus_wdata_d = '0;
        end
      end
      // data_ok without addr_ok here is not ours yet and is ignored.
      GRANT: if (bus_addr_ok) begin
        bus_req_d = 1'b0;
        if (bus_data_ok) complete = 1'b1;
        else             state_d  = WAIT_DATA;
      end
      WAIT_DATA: if (bus_data_ok) complete = 1'b1;
      DONE: begin
        state_d = IDLE;
`ifdef MEM_ARB_RR_EN
        last_owner_d = owner_q;
`endif
      end
      default: state_d = IDLE;
    endcase
    if (complete) begin
      state_d = DONE;
      if (owner_q == OWN_DATA) begin
        data_ready_d = 1'b1;
        if (!bus_wr_q) data_rdata_d = bus_rdata;
      end else begin
        inst_ready_d = 1'b1;
        inst_rdata_d = bus_rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      owner_q      <= OWN_INST;
      bus_req_q    <= 1'b0;
      bus_wr_q     <= 1'b0;
      bus_size_q   <= '0;
      bus_wstrb_q  <= '0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
      inst_ready_q <= 1'b0;
      data_ready_q <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_owner_q <= OWN_INST;
`endif
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      bus_req_q    <= bus_req_d;
      bus_wr_q     <= bus_wr_d;
      bus_size_q   <= bus_size_d;
      bus_wstrb_q  <= bus_wstrb_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
      inst_ready_q <= inst_ready_d;
      data_ready_q <= data_ready_d;
`ifdef MEM_ARB_RR_EN
      last_owner_q <= last_owner_d;
`endif
    end
  end

  assign bus_req    = bus_req_q;
  assign bus_wr     = bus_wr_q;
  assign bus_size   = bus_size_q;
  assign bus_wstrb  = bus_wstrb_q;
  assign bus_addr   = bus_addr_q;
  assign bus_wdata  = bus_wdata_q;
  assign inst_rdata = inst_rdata_q;
  assign data_rdata = data_rdata_q;
  assign inst_ready = inst_ready_q;
  assign data_ready = data_ready_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: fetch, store, byte load, spurious data_ok, conflicts, mid-transaction reset.
module tb_mem_bus_arbiter;
  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_ready, data_req, data_wr, data_ready;
  logic [31:0] inst_addr, inst_rdata, data_addr, data_wdata, data_rdata;
  logic [2:0]  data_size, bus_size;
  logic [3:0]  data_wstrb, bus_wstrb;
  logic        bus_req, bus_wr, bus_addr_ok, bus_data_ok;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_ready(inst_ready),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata), .data_ready(data_ready),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_wstrb(bus_wstrb),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
  );

  task automatic test_reset;
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus_req, bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata} !== '0) begin
      errors++; $display("FAIL reset_bus got req=%b addr=%h wdata=%h want all 0", bus_req, bus_addr, bus_wdata);
    end
    checks++;
    if ({inst_ready, inst_rdata, data_ready, data_rdata} !== '0) begin
      errors++; $display("FAIL reset_resp got %b %h %b %h want all 0", inst_ready, inst_rdata, data_ready, data_rdata);
    end
    resetn = 1'b1;
    @(negedge clk);
    checks++;
    if (bus_req !== 1'b0) begin errors++; $display("FAIL idle_no_req got bus_req=%b want 0", bus_req); end
  endtask

  task automatic test_fetch;
    inst_req = 1'b1; inst_addr = 32'hBFC00000;
    @(negedge clk);
    checks++;
    if ({bus_req, bus_wr, bus_size, bus_wstrb, bus_addr} !== {1'b1, 1'b0, 3'd2, 4'd0, 32'hBFC00000}) begin
      errors++; $display("FAIL fetch_bus got req=%b wr=%b size=%0d addr=%h want 1 0 2 bfc00000", bus_req, bus_wr, bus_size, bus_addr);
    end
    bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'h3C080001;
    @(negedge clk);
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; inst_req = 1'b0;
    checks++;
    if ({inst_ready, data_ready, bus_req} !== 3'b100) begin
      errors++; $display("FAIL fetch_ready got inst=%b data=%b bus_req=%b want 1 0 0", inst_ready, data_ready, bus_req);
    end
    checks++;
    if (inst_rdata !== 32'h3C080001) begin errors++; $display("FAIL fetch_rdata got %h want 3c080001", inst_rdata); end
    @(negedge clk);
    checks++;
    if (inst_ready !== 1'b0) begin errors++; $display("FAIL fetch_pulse got inst_ready=%b want 0", inst_ready); end
  endtask

  task automatic test_store;
    data_req = 1'b1; data_wr = 1'b1; data_size = 3'd2; data_wstrb = 4'hF;
    data_addr = 32'h80000010; data_wdata = 32'hDEADBEEF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({bus_req, bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata} !== {1'b1, 1'b1, 3'd2, 4'hF, 32'h80000010, 32'hDEADBEEF}) begin
        errors++; $display("FAIL store_grant%0d got req=%b wr=%b addr=%h wdata=%h want 1 1 80000010 deadbeef", i, bus_req, bus_wr, bus_addr, bus_wdata);
      end
      if (i == 0) begin data_addr = 32'h0; data_wdata = 32'h0; end
      if (i == 3) bus_addr_ok = 1'b1;
    end
    @(negedge clk);
    bus_addr_ok = 1'b0;
    checks++;
    if ({bus_req, data_ready, bus_addr, bus_wdata} !== {1'b0, 1'b0, 32'h80000010, 32'hDEADBEEF}) begin
      errors++; $display("FAIL store_wait got req=%b ready=%b addr=%h wdata=%h want 0 0 80000010 deadbeef", bus_req, data_ready, bus_addr, bus_wdata);
    end
    @(negedge clk);
    checks++;
    if (data_ready !== 1'b0) begin errors++; $display("FAIL store_early got data_ready=%b want 0", data_ready); end
    bus_data_ok = 1'b1; bus_rdata = 32'h12345678;
    @(negedge clk);
    bus_data_ok = 1'b0; data_req = 1'b0; data_wr = 1'b0;
    checks++;
    if ({data_ready, inst_ready} !== 2'b10) begin errors++; $display("FAIL store_ready got data=%b inst=%b want 1 0", data_ready, inst_ready); end
    checks++;
    if (data_rdata !== 32'h0) begin errors++; $display("FAIL store_rdata got %h want 00000000", data_rdata); end
    @(negedge clk);
    checks++;
    if (data_ready !== 1'b0) begin errors++; $display("FAIL store_pulse got data_ready=%b want 0", data_ready); end
  endtask

  task automatic test_byte_load;
    data_req = 1'b1; data_wr = 1'b0; data_size = 3'd0; data_wstrb = 4'h0;
    data_addr = 32'h80000003; data_wdata = 32'h0;
    @(negedge clk);
    checks++;
    if ({bus_req, bus_wr, bus_size, bus_addr} !== {1'b1, 1'b0, 3'd0, 32'h80000003}) begin
      errors++; $display("FAIL byte_bus got req=%b wr=%b size=%0d addr=%h want 1 0 0 80000003", bus_req, bus_wr, bus_size, bus_addr);
    end
    bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'hAB000000;
    @(negedge clk);
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; data_req = 1'b0;
    checks++;
    if ({data_ready, data_rdata} !== {1'b1, 32'hAB000000}) begin
      errors++; $display("FAIL byte_rdata got ready=%b rdata=%h want 1 ab000000", data_ready, data_rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_spurious;
    inst_req = 1'b1; inst_addr = 32'hBFC00004;
    @(negedge clk);
    bus_data_ok = 1'b1; bus_rdata = 32'h11111111;
    @(negedge clk);
    checks++;
    if ({bus_req, inst_ready} !== 2'b10) begin
      errors++; $display("FAIL spurious_ignored got bus_req=%b inst_ready=%b want 1 0", bus_req, inst_ready);
    end
    bus_addr_ok = 1'b1; bus_rdata = 32'h22222222;
    @(negedge clk);
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; inst_req = 1'b0;
    checks++;
    if ({inst_ready, inst_rdata} !== {1'b1, 32'h22222222}) begin
      errors++; $display("FAIL spurious_done got ready=%b rdata=%h want 1 22222222", inst_ready, inst_rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_conflict;
    logic exp_data [4];
    int n;
`ifdef MEM_ARB_RR_EN
    exp_data = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_data = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    inst_req = 1'b1; inst_addr = 32'hBFC00100;
    data_req = 1'b1; data_wr = 1'b0; data_size = 3'd2; data_wstrb = 4'h0; data_addr = 32'h80000100;
    for (int t = 0; t < 4; t++) begin
      n = 0;
      @(negedge clk);
      while (bus_req !== 1'b1 && n < 6) begin @(negedge clk); n++; end
      checks++;
      if (bus_req !== 1'b1) begin
        errors++; $display("FAIL conflict%0d_timeout got bus_req=%b want 1", t, bus_req);
      end else begin
        checks++;
        if (bus_addr !== (exp_data[t] ? 32'h80000100 : 32'hBFC00100)) begin
          errors++; $display("FAIL conflict%0d_winner got addr=%h want %s port", t, bus_addr, exp_data[t] ? "data" : "inst");
        end
        bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'hC0DE0000 + t;
        @(negedge clk);
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
        checks++;
        if ({inst_ready, data_ready} !== {~exp_data[t], exp_data[t]}) begin
          errors++; $display("FAIL conflict%0d_ready got inst=%b data=%b want %b %b", t, inst_ready, data_ready, ~exp_data[t], exp_data[t]);
        end
      end
    end
    inst_req = 1'b0; data_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    inst_req = 1'b1; inst_addr = 32'hBFC00008;
    @(negedge clk);
    bus_addr_ok = 1'b1;
    @(negedge clk);
    bus_addr_ok = 1'b0;
    checks++;
    if (bus_req !== 1'b0) begin errors++; $display("FAIL mid_wait got bus_req=%b want 0", bus_req); end
    resetn = 1'b0; inst_req = 1'b0;
    #1;
    checks++;
    if ({bus_req, bus_addr, inst_ready, inst_rdata, data_ready, data_rdata} !== '0) begin
      errors++; $display("FAIL mid_reset got req=%b addr=%h inst_rdata=%h data_rdata=%h want all 0", bus_req, bus_addr, inst_rdata, data_rdata);
    end
    bus_data_ok = 1'b1; bus_rdata = 32'h55555555;
    @(negedge clk);
    bus_data_ok = 1'b0; resetn = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if ({inst_ready, data_ready, bus_req} !== 3'b000) begin
        errors++; $display("FAIL mid_no_pulse got inst=%b data=%b req=%b want 0 0 0", inst_ready, data_ready, bus_req);
      end
    end
    inst_req = 1'b1; inst_addr = 32'hBFC00000;
    @(negedge clk);
    checks++;
    if ({bus_req, bus_addr} !== {1'b1, 32'hBFC00000}) begin
      errors++; $display("FAIL mid_refetch_bus got req=%b addr=%h want 1 bfc00000", bus_req, bus_addr);
    end
    bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'h3C080001;
    @(negedge clk);
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; inst_req = 1'b0;
    checks++;
    if ({inst_ready, inst_rdata} !== {1'b1, 32'h3C080001}) begin
      errors++; $display("FAIL mid_refetch_done got ready=%b rdata=%h want 1 3c080001", inst_ready, inst_rdata);
    end
    @(negedge clk);
  endtask

  initial begin
    resetn = 1'b0;
    inst_req = 1'b0; inst_addr = '0;
    data_req = 1'b0; data_wr = 1'b0; data_size = '0; data_wstrb = '0; data_addr = '0; data_wdata = '0;
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = '0;
    test_reset;
    test_fetch;
    test_store;
    test_byte_load;
    test_spurious;
    test_conflict;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
